// File: rtl/aes128_stream_ctrl_if.sv
// ============================================================================
// Module   : aes128_stream_ctrl_if
// Brief    : Word-stream handshake bundle between host and AES stream controller
// Revision : 1.0
// ============================================================================
`default_nettype none

interface aes128_stream_ctrl_if;
  logic        sel_cypher;
  logic        reuse_key;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] out_data;

  modport master (
    output sel_cypher, reuse_key, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  sel_cypher, reuse_key, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/aes128_stream_ctrl.sv
// ============================================================================
// Module   : aes128_stream_ctrl
// Brief    : Assembles key/message words for the AES-128 core, runs it for
//            LATENCY cycles and streams the 128-bit result back as 4 words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes128_stream_ctrl #(
  parameter int unsigned LATENCY = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  aes128_stream_ctrl_if.slave     bus,
  output logic                    core_rst,
  output logic                    core_sel,
  output logic [0:127]            core_key,
  output logic [0:127]            core_message,
  input  logic [0:127]            core_result,
  output logic                    busy
);

  localparam logic [7:0] LAT8 = 8'(LATENCY);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   wc_q, wc_d;
  logic [7:0]   rc_q, rc_d;
  logic [1:0]   oc_q, oc_d;
  logic         reuse_q, reuse_d;
  logic         sel_q, sel_d;
  logic [0:127] key_q, key_d;
  logic [0:127] msg_q, msg_d;
  logic [0:127] buf_q, buf_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [0:31]  out_data_q, out_data_d;
  logic         core_rst_q, core_rst_d;
  logic         busy_q, busy_d;

  logic         w_in_acc;
  logic         w_out_acc;
  logic         w_reuse_eff;
  logic         w_last_word;
  logic [1:0]   w_oc_nxt;

  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    rc_d        = rc_q;
    oc_d        = oc_q;
    reuse_d     = reuse_q;
    sel_d       = sel_q;
    key_d       = key_q;
    msg_d       = msg_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    w_in_acc    = bus.in_valid & in_ready_q;
    w_out_acc   = out_valid_q & bus.out_ready;
    // The mode flag is live only on the first word; later words use the latched copy
    w_reuse_eff = (wc_q == 3'd0) ? bus.reuse_key : reuse_q;
    w_last_word = w_reuse_eff ? (wc_q == 3'd3) : (wc_q == 3'd7);
    w_oc_nxt    = oc_q + 2'd1;

    case (state_q)
      LOAD: begin
        if (w_in_acc) begin
          if (wc_q == 3'd0) begin
            sel_d   = bus.sel_cypher;
            reuse_d = bus.reuse_key;
          end
          if (!w_reuse_eff && !wc_q[2]) begin
            key_d[{wc_q[1:0], 5'd0} +: 32] = bus.in_data;
          end else begin
            msg_d[{wc_q[1:0], 5'd0} +: 32] = bus.in_data;
          end
          if (w_last_word) begin
            state_d = RUN;
            wc_d    = 3'd0;
            rc_d    = 8'd0;
          end else begin
            wc_d = wc_q + 3'd1;
          end
        end
      end

      RUN: begin
        rc_d = rc_q + 8'd1;
        if (rc_q == LAT8) begin
          buf_d       = core_result;
          out_data_d  = core_result[0:31];
          out_valid_d = 1'b1;
          oc_d        = 2'd0;
          state_d     = DRAIN;
        end
      end

      DRAIN: begin
        if (w_out_acc) begin
          oc_d = w_oc_nxt;
          if (oc_q == 2'd3) begin
            out_valid_d = 1'b0;
            state_d     = LOAD;
          end else begin
            out_data_d = buf_q[{w_oc_nxt, 5'd0} +: 32];
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase

    // Status outputs are registered copies decoded from the next state
    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != LOAD);
    core_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      wc_q        <= 3'd0;
      rc_q        <= 8'd0;
      oc_q        <= 2'd0;
      reuse_q     <= 1'b0;
      sel_q       <= 1'b0;
      key_q       <= '0;
      msg_q       <= '0;
      buf_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      rc_q        <= rc_d;
      oc_q        <= oc_d;
      reuse_q     <= reuse_d;
      sel_q       <= sel_d;
      key_q       <= key_d;
      msg_q       <= msg_d;
      buf_q       <= buf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign core_rst      = core_rst_q;
  assign core_sel      = sel_q;
  assign core_key      = key_q;
  assign core_message  = msg_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_aes128_stream_ctrl.sv
// ============================================================================
// Module   : tb_aes128_stream_ctrl
// Brief    : Scoreboard bench for aes128_stream_ctrl with a table-driven core model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes128_stream_ctrl;
  localparam int LAT = 11;

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes128_stream_ctrl_if ifc ();

  logic         core_rst, core_sel, busy;
  logic [127:0] core_key, core_message, core_result;

  aes128_stream_ctrl #(.LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (rst),
    .bus          (ifc),
    .core_rst     (core_rst),
    .core_sel     (core_sel),
    .core_key     (core_key),
    .core_message (core_message),
    .core_result  (core_result),
    .busy         (busy)
  );

  // Known AES-128 vectors; anything else maps to a simple keyed stand-in
  function automatic logic [127:0] aes_ref(input logic s, input logic [127:0] k, input logic [127:0] m);
    if (s && k == FK && m == FP) return FC;
    if (!s && k == FK && m == FC) return FP;
    if (s && k == 128'h0 && m == 128'h0) return ZC;
    return m ^ k ^ {4{s ? 32'h5a5a5a5a : 32'ha5a5a5a5}};
  endfunction

  // Core result is only meaningful after LATENCY edges with core_rst low
  int cc;
  always @(posedge clk or posedge rst) begin
    if (rst)           cc <= 0;
    else if (core_rst) cc <= 0;
    else               cc <= cc + 1;
  end
  assign core_result = (!core_rst && cc >= LAT) ? aes_ref(core_sel, core_key, core_message)
                                                : {4{32'hbad0bad0}};

  logic [31:0]  q[$];
  logic [31:0]  ew;
  int           n_vec = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           acc = 0;
  int           e0 = 0;
  int           oword = 0;
  int           scnt = 0;
  logic         exp_busy = 1'b0;
  logic         pend = 1'b0;
  logic         prev_stall = 1'b0;
  logic         prev_ov = 1'b0;
  logic [31:0]  prev_data = '0;
  logic [127:0] key_m = '0;
  logic         stall_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; prev_ov = 1'b0; prev_stall = 1'b0; oword = 0;
      end else begin
        if (pend) begin
          chk("in_ready_after_drain", {ifc.in_ready, ifc.out_valid}, 2'b10);
          exp_busy = 1'b0;
          pend = 1'b0;
        end
        chk("busy_in_ready", {busy, ifc.in_ready}, {exp_busy, !exp_busy});
        if (ifc.out_valid && !prev_ov) chk("latency", cyc - e0, LAT + 1);
        if (prev_stall) chk("stall_hold", {ifc.out_valid, ifc.out_data}, {1'b1, prev_data});
        if (ifc.in_valid && ifc.in_ready) acc++;
        if (ifc.out_valid && ifc.out_ready) begin
          if (q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_out: got %h expected none", ifc.out_data);
          end else begin
            ew = q.pop_front();
            chk("out_word", ifc.out_data, ew);
          end
          if (oword == 3) begin pend = 1'b1; oword = 0; end
          else oword++;
        end
        prev_stall = ifc.out_valid && !ifc.out_ready;
        prev_data  = ifc.out_data;
        prev_ov    = ifc.out_valid;
      end
    end
  end

  // Sink: always ready, or 5 stalled cycles before each word
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!stall_en) ifc.out_ready = 1'b1;
      else if (!ifc.out_valid) begin ifc.out_ready = 1'b0; scnt = 0; end
      else if (scnt < 5) begin ifc.out_ready = 1'b0; scnt++; end
      else begin ifc.out_ready = 1'b1; scnt = 0; end
    end
  end

  task automatic send_word(input logic [31:0] d, input int gap);
    int b = 0;
    repeat (gap) begin ifc.in_valid = 1'b0; @(posedge clk); #1; end
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    while (!ifc.in_ready && b < 3000) begin @(posedge clk); #1; b++; end
    if (b >= 3000) begin
      n_vec++; n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic sel, input logic reuse, input logic [127:0] key,
                            input logic [127:0] msg, input logic gaps, input logic hold);
    int           words = reuse ? 4 : 8;
    logic [127:0] k = reuse ? key_m : key;
    logic [127:0] r;
    logic [31:0]  w;
    int           a0;
    if (!reuse) key_m = key;
    r = aes_ref(sel, k, msg);
    for (int i = 0; i < 4; i++) q.push_back(r[127 - 32*i -: 32]);
    a0 = acc;
    ifc.sel_cypher = sel;
    ifc.reuse_key  = reuse;
    for (int i = 0; i < words; i++) begin
      if (!reuse && i < 4) w = key[127 - 32*i -: 32];
      else                 w = msg[127 - 32*(i % 4) -: 32];
      send_word(w, gaps ? int'($urandom_range(0, 3)) : 0);
      if (i == 0) begin ifc.sel_cypher = ~sel; ifc.reuse_key = ~reuse; end
    end
    e0 = cyc;
    exp_busy = 1'b1;
    chk("accepted_words", acc - a0, words);
    ifc.in_valid = hold;
    ifc.in_data  = 32'hdeadbeef;
  endtask

  task automatic drain();
    int b = 0;
    while ((q.size() != 0 || pend) && b < 5000) begin @(posedge clk); b++; end
    if (b >= 5000) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", q.size());
      q.delete();
    end
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0;
    ifc.sel_cypher = 1'b0; ifc.reuse_key = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {ifc.in_ready, ifc.out_valid, ifc.out_data, core_rst, core_sel, busy},
        {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    chk("reset_key", core_key, 128'h0);
    chk("reset_msg", core_message, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 encrypt, then decrypt reusing the stored key
    send_block(1'b1, 1'b0, FK, FP, 1'b0, 1'b0);
    drain();
    send_block(1'b0, 1'b1, 128'h0, FC, 1'b0, 1'b0);
    drain();

    // Backpressure on both streams
    stall_en = 1'b1;
    send_block(1'b1, 1'b0, FK, FP, 1'b1, 1'b0);
    drain();
    stall_en = 1'b0;

    // Reset when rc == 5
    send_block(1'b1, 1'b1, 128'h0, FP, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {ifc.in_ready, ifc.out_valid, ifc.out_data, core_rst, core_sel, busy},
        {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    chk("abort_key", core_key, 128'h0);
    chk("abort_msg", core_message, 128'h0);
    q.delete();
    exp_busy = 1'b0;
    key_m = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_block(1'b1, 1'b1, 128'h0, FP, 1'b0, 1'b0);
    drain();
    send_block(1'b1, 1'b1, 128'h0, 128'h0, 1'b0, 1'b0);
    drain();

    // deadbeef held valid while busy, then a back-to-back decrypt block
    send_block(1'b1, 1'b0, FK, FP, 1'b0, 1'b1);
    send_block(1'b0, 1'b1, 128'h0, FC, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
